video_stream_sink: RTL and testbench

- Receiver for the processed video stream: consumes the pixel-strobed RGB and sync/blank output of the video mux.
- Writes active pixels into an external line buffer, one write per pixel.
- Measures frame geometry: active width, active height and total lines, and detects PAL versus NTSC from the line count.
- Feeds the scaler/capture path and the OSD "video mode" status readout.

---
 rtl/video_stream_sink_if.sv | 27 ++
 rtl/video_stream_sink.sv | 187 ++++++++++++++++++
 tb/tb_video_stream_sink.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_sink_if.sv
// Pixel stream from the video mux plus the line buffer write port of video_stream_sink.
interface video_stream_sink_if #(
  parameter int ADDR_W = 9
);
  logic              pix_ce;
  logic              hblank;
  logic              vblank;
  logic              hsync;
  logic              vsync;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_line;
  logic [23:0]       wr_data;

  modport master (
    output pix_ce, hblank, vblank, hsync, vsync, red, green, blue,
    input  wr_en, wr_addr, wr_line, wr_data
  );

  modport slave (
    input  pix_ce, hblank, vblank, hsync, vsync, red, green, blue,
    output wr_en, wr_addr, wr_line, wr_data
  );
endinterface

// File: rtl/video_stream_sink.sv
// Video stream receiver: writes active pixels to a line buffer and measures frame geometry.
// Define VIDEO_STREAM_SINK_SIG_EN to build the per-frame signature accumulator.
module video_stream_sink #(
  parameter int ADDR_W    = 9,
  parameter int PAL_LINES = 288
) (
  input  logic               clk_sys,
  input  logic               reset,
  video_stream_sink_if.slave vid,
  output logic               line_done,
  output logic               frame_done,
  output logic [ADDR_W:0]    meas_width,
  output logic [8:0]         meas_height,
  output logic [9:0]         meas_total,
  output logic               pal_detect,
  output logic               stable,
  output logic [15:0]        frame_sig
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [9:0]      PAL_TH    = 10'(PAL_LINES);
  localparam logic [ADDR_W:0] HCNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] HCNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic              prev_hblank_r;
  logic              prev_hsync_r;
  logic              prev_vsync_r;
  logic [ADDR_W:0]   hcnt_r;
  logic [8:0]        vcnt_r;
  logic [9:0]        tcnt_r;
  logic [ADDR_W:0]   snap_width_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [8:0]        wr_line_r;
  logic [23:0]       wr_data_r;

  logic              run_s;
  logic              hb_rise_s;
  logic              hs_rise_s;
  logic              vs_rise_s;
  logic              wr_ok_s;
  logic              line_end_s;
  logic              same_s;
  logic              nonzero_s;
  logic [ADDR_W:0]   width_new_s;
  logic [8:0]        vcnt_new_s;
  logic [9:0]        tcnt_new_s;

  assign vid.wr_en   = wr_en_r;
  assign vid.wr_addr = wr_addr_r;
  assign vid.wr_line = wr_line_r;
  assign vid.wr_data = wr_data_r;

  // Edge detection and counter values after this sample's line end and hsync (line end first).
  always_comb begin
    run_s      = (state_r == ST_RUN);
    hb_rise_s  = vid.pix_ce & vid.hblank & ~prev_hblank_r;
    hs_rise_s  = vid.pix_ce & vid.hsync & ~prev_hsync_r;
    vs_rise_s  = vid.pix_ce & vid.vsync & ~prev_vsync_r;
    wr_ok_s    = run_s & vid.pix_ce & ~vid.hblank & ~vid.vblank & ~hcnt_r[ADDR_W];
    line_end_s = run_s & hb_rise_s & ~vid.vblank & (hcnt_r != HCNT_ZERO);
    if (line_end_s) begin
      width_new_s = hcnt_r;
      vcnt_new_s  = (vcnt_r == 9'd511) ? vcnt_r : vcnt_r + 9'd1;
    end else begin
      width_new_s = meas_width;
      vcnt_new_s  = vcnt_r;
    end
    if (run_s && hs_rise_s) begin
      tcnt_new_s = (tcnt_r == 10'd1023) ? tcnt_r : tcnt_r + 10'd1;
    end else begin
      tcnt_new_s = tcnt_r;
    end
    same_s    = (width_new_s == snap_width_r) && (vcnt_new_s == meas_height) &&
                (tcnt_new_s == meas_total);
    nonzero_s = (width_new_s != HCNT_ZERO) || (vcnt_new_s != 9'd0) || (tcnt_new_s != 10'd0);
  end

  // Next state: leave IDLE on the first vsync rising edge and stay in RUN until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vs_rise_s) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Edge history, counters, line buffer write port and latched geometry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      prev_hblank_r <= 1'b0;
      prev_hsync_r  <= 1'b0;
      prev_vsync_r  <= 1'b0;
      hcnt_r        <= HCNT_ZERO;
      vcnt_r        <= 9'd0;
      tcnt_r        <= 10'd0;
      snap_width_r  <= HCNT_ZERO;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_line_r     <= 9'd0;
      wr_data_r     <= 24'd0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      meas_width    <= HCNT_ZERO;
      meas_height   <= 9'd0;
      meas_total    <= 10'd0;
      pal_detect    <= 1'b0;
      stable        <= 1'b0;
    end else begin
      wr_en_r    <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (vid.pix_ce) begin
        prev_hblank_r <= vid.hblank;
        prev_hsync_r  <= vid.hsync;
        prev_vsync_r  <= vid.vsync;
      end
      // hcnt stops at 2^ADDR_W, so pixels past the buffer are dropped without a write.
      if (wr_ok_s) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= hcnt_r[ADDR_W-1:0];
        wr_line_r <= vcnt_r;
        wr_data_r <= {vid.red, vid.green, vid.blue};
        hcnt_r    <= hcnt_r + HCNT_ONE;
      end
      if (line_end_s) begin
        line_done  <= 1'b1;
        meas_width <= hcnt_r;
        hcnt_r     <= HCNT_ZERO;
      end
      vcnt_r <= vcnt_new_s;
      tcnt_r <= tcnt_new_s;
      if (vs_rise_s) begin
        if (run_s) begin
          frame_done   <= 1'b1;
          meas_height  <= vcnt_new_s;
          meas_total   <= tcnt_new_s;
          pal_detect   <= (tcnt_new_s > PAL_TH);
          snap_width_r <= width_new_s;
          if (same_s && nonzero_s) stable <= 1'b1;
          else if (!same_s)        stable <= 1'b0;
        end
        hcnt_r <= HCNT_ZERO;
        vcnt_r <= 9'd0;
        tcnt_r <= 10'd0;
      end
    end
  end

`ifdef VIDEO_STREAM_SINK_SIG_EN
  logic [15:0] acc_r;

  function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [7:0] r,
                                           input logic [7:0] g, input logic [7:0] b);
    return {acc[14:0], acc[15]} ^ {r ^ b, g};
  endfunction

  // Signature over the accepted writes of a frame; also cleared on entry to RUN.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_r     <= 16'd0;
      frame_sig <= 16'd0;
    end else if (vs_rise_s) begin
      if (run_s) frame_sig <= acc_r;
      acc_r <= 16'd0;
    end else if (wr_ok_s) begin
      acc_r <= sig_step(acc_r, vid.red, vid.green, vid.blue);
    end
  end
`else
  assign frame_sig = 16'd0;
`endif

endmodule

// File: tb/tb_video_stream_sink.sv
// Randomized self-checking bench for video_stream_sink against a sample-level reference model.
module tb_video_stream_sink;

  localparam int ADDR_W = 9;
  localparam int MAXW   = 1 << ADDR_W;
`ifdef VIDEO_STREAM_SINK_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              line_done;
  logic              frame_done;
  logic [ADDR_W:0]   meas_width;
  logic [8:0]        meas_height;
  logic [9:0]        meas_total;
  logic              pal_detect;
  logic              stable;
  logic [15:0]       frame_sig;

  video_stream_sink_if #(.ADDR_W(ADDR_W)) vif ();

  video_stream_sink #(.ADDR_W(ADDR_W), .PAL_LINES(288)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vid         (vif),
    .line_done   (line_done),
    .frame_done  (frame_done),
    .meas_width  (meas_width),
    .meas_height (meas_height),
    .meas_total  (meas_total),
    .pal_detect  (pal_detect),
    .stable      (stable),
    .frame_sig   (frame_sig)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state, expressed directly in terms of frame/line bookkeeping.
  bit m_run, m_phb, m_phs, m_pvs;
  int m_h, m_v, m_t, m_mw, m_mh, m_mt, m_sw;
  bit m_pal, m_st;
  logic [15:0] m_acc, m_sig;
  bit e_wr, e_ld, e_fd;
  int e_addr, e_line;
  logic [23:0] e_data;

  typedef struct { int w; int h; int t; int pal; int st; int sig; int wr; } hist_t;
  hist_t hist[$];
  int obs_wr = 0;
  int gap_lo = 0;
  int gap_hi = 1;

  task automatic model_reset();
    m_run = 0; m_phb = 0; m_phs = 0; m_pvs = 0;
    m_h = 0; m_v = 0; m_t = 0; m_mw = 0; m_mh = 0; m_mt = 0; m_sw = 0;
    m_pal = 0; m_st = 0; m_acc = 16'd0; m_sig = 16'd0;
  endtask

  task automatic model_step(input bit hb, input bit vb, input bit hs, input bit vs,
                            input logic [23:0] rgb);
    bit hbr, hsr, vsr, same;
    hbr = hb && !m_phb; hsr = hs && !m_phs; vsr = vs && !m_pvs;
    m_phb = hb; m_phs = hs; m_pvs = vs;
    e_wr = 0; e_ld = 0; e_fd = 0;
    if (!m_run) begin
      if (vsr) begin
        m_run = 1; m_h = 0; m_v = 0; m_t = 0; m_acc = 16'd0;
      end
    end else begin
      if (!hb && !vb && m_h < MAXW) begin
        e_wr = 1; e_addr = m_h; e_line = m_v; e_data = rgb;
        m_acc = {m_acc[14:0], m_acc[15]} ^ {rgb[23:16] ^ rgb[7:0], rgb[15:8]};
        m_h++;
      end
      if (hbr && !vb && m_h != 0) begin
        e_ld = 1; m_mw = m_h; m_h = 0;
        if (m_v < 511) m_v++;
      end
      if (hsr && m_t < 1023) m_t++;
      if (vsr) begin
        e_fd = 1;
        same = (m_mw == m_sw) && (m_v == m_mh) && (m_t == m_mt);
        if (same && (m_mw != 0 || m_v != 0 || m_t != 0)) m_st = 1;
        else if (!same) m_st = 0;
        m_sw = m_mw; m_mh = m_v; m_mt = m_t; m_pal = (m_t > 288);
        m_sig = m_acc; m_acc = 16'd0;
        m_h = 0; m_v = 0; m_t = 0;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wr_en"}, 32'(vif.wr_en), 32'd0);
    check_val({tag, "_wr_addr"}, 32'(vif.wr_addr), 32'd0);
    check_val({tag, "_wr_line"}, 32'(vif.wr_line), 32'd0);
    check_val({tag, "_wr_data"}, 32'(vif.wr_data), 32'd0);
    check_val({tag, "_pulses"}, 32'({line_done, frame_done}), 32'd0);
    check_val({tag, "_meas"}, 32'(meas_width) | 32'(meas_height) | 32'(meas_total), 32'd0);
    check_val({tag, "_flags"}, 32'({pal_detect, stable}), 32'd0);
    check_val({tag, "_sig"}, 32'(frame_sig), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; vif.pix_ce = 1'b0;
    @(negedge clk_sys);
    check_zero("reset");
    reset = 1'b0;
    model_reset();
    obs_wr = 0;
  endtask

  // One pix_ce sample followed by a random number of non-ce clocks carrying garbage.
  task automatic send(input bit hb, input bit vb, input bit hs, input bit vs, input logic [23:0] rgb);
    int gap;
    vif.pix_ce = 1'b1; vif.hblank = hb; vif.vblank = vb; vif.hsync = hs; vif.vsync = vs;
    {vif.red, vif.green, vif.blue} = rgb;
    model_step(hb, vb, hs, vs, rgb);
    @(negedge clk_sys);
    check_val("wr_en", 32'(vif.wr_en), 32'(e_wr));
    if (e_wr) begin
      check_val("wr_addr", 32'(vif.wr_addr), 32'(e_addr));
      check_val("wr_line", 32'(vif.wr_line), 32'(e_line));
      check_val("wr_data", 32'(vif.wr_data), 32'(e_data));
    end
    check_val("line_done", 32'(line_done), 32'(e_ld));
    check_val("frame_done", 32'(frame_done), 32'(e_fd));
    if (e_ld || e_fd) check_val("meas_width", 32'(meas_width), 32'(m_mw));
    if (e_fd) begin
      check_val("meas_height", 32'(meas_height), 32'(m_mh));
      check_val("meas_total", 32'(meas_total), 32'(m_mt));
      check_val("pal_detect", 32'(pal_detect), 32'(m_pal));
      check_val("stable", 32'(stable), 32'(m_st));
      check_val("frame_sig", 32'(frame_sig), SIG_EN ? 32'(m_sig) : 32'd0);
    end
    if (vif.wr_en) obs_wr++;
    if (frame_done) begin
      hist.push_back('{int'(meas_width), int'(meas_height), int'(meas_total),
                       int'(pal_detect), int'(stable), int'(frame_sig), obs_wr});
      obs_wr = 0;
    end
    gap = $urandom_range(gap_hi, gap_lo);
    for (int i = 0; i < gap; i++) begin
      vif.pix_ce = 1'b0;
      {vif.hblank, vif.vblank, vif.hsync, vif.vsync} = 4'($urandom);
      {vif.red, vif.green, vif.blue} = 24'($urandom);
      @(negedge clk_sys);
      check_val("idle_pulses", 32'({vif.wr_en, line_done, frame_done}), 32'd0);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int seed, input int l, input int p);
    int v;
    v = seed * 7919 + l * 131 + p * 977 + (l ^ p) * 65537;
    return v[23:0];
  endfunction

  // Frame: vsync rise shares a sample with the hblank/hsync rise that closes the last line.
  task automatic frame(input int width, input int act, input int total, input int seed,
                       input int rst_at, input bit tweak);
    int  n;
    bit  pvb, vb, vs;
    logic [23:0] d;
    n = 0; pvb = 1'b0;
    for (int l = 0; l < total; l++) begin
      vb = (l < total - act);
      vs = (l < 3);
      send(1'b1, pvb, 1'b1, vs, pix_rgb(seed, l, 999));
      send(1'b1, vb, 1'b0, vs, pix_rgb(seed, l, 998));
      if (!vb) begin
        for (int p = 0; p < width; p++) begin
          if (n == rst_at) do_reset();
          n++;
          d = pix_rgb(seed, l, p);
          if (tweak && l == total - 1 && p == 0) d = d ^ 24'h000001;
          send(1'b0, 1'b0, 1'b0, vs, d);
        end
      end
      pvb = vb;
    end
  endtask

  initial begin
    int s;
    reset = 1'b1;
    vif.pix_ce = 1'b0; vif.hblank = 1'b0; vif.vblank = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0;
    vif.red = 8'd0; vif.green = 8'd0; vif.blue = 8'd0;
    repeat (2) @(negedge clk_sys);
    check_zero("por");
    reset = 1'b0;
    model_reset();

    // Active pixels before any vsync edge must not be written.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));

    s = int'($urandom_range(1000, 1));
    for (int f = 0; f < 4; f++) frame(8, 243, 263, s + f, -1, 1'b0);
    for (int f = 0; f < 2; f++) frame(8, 292, 313, s + 10 + f, -1, 1'b0);
    gap_lo = 3; gap_hi = 3;
    for (int f = 0; f < 2; f++) frame(6, 4, 10, s + 20 + f, -1, 1'b0);
    gap_lo = 0; gap_hi = 1;
    frame(600, 1, 4, s + 30, -1, 1'b0);
    frame(8, 5, 8, s + 40, 20, 1'b0);
    frame(8, 5, 8, s + 41, -1, 1'b0);
    frame(8, 5, 8, s + 42, -1, 1'b0);
    frame(8, 5, 8, 77, -1, 1'b0);
    frame(8, 5, 8, 77, -1, 1'b0);
    frame(8, 5, 8, 77, -1, 1'b1);
    frame(8, 5, 8, 78, -1, 1'b0);

    check_val("hist_len", 32'(hist.size()), 32'd14);
    if (hist.size() >= 14) begin
      check_val("ntsc_width", 32'(hist[0].w), 32'd8);
      check_val("ntsc_height", 32'(hist[0].h), 32'd243);
      check_val("ntsc_total", 32'(hist[0].t), 32'd263);
      check_val("ntsc_pal", 32'(hist[0].pal), 32'd0);
      check_val("ntsc_stable_f1", 32'(hist[0].st), 32'd0);
      check_val("ntsc_writes", 32'(hist[0].wr), 32'd1944);
      check_val("ntsc_stable_f2", 32'(hist[1].st), 32'd1);
      check_val("ntsc_stable_f3", 32'(hist[2].st), 32'd1);
      check_val("pal_total", 32'(hist[4].t), 32'd313);
      check_val("pal_height", 32'(hist[4].h), 32'd292);
      check_val("pal_flag", 32'(hist[4].pal), 32'd1);
      check_val("pal_stable_f1", 32'(hist[4].st), 32'd0);
      check_val("pal_stable_f2", 32'(hist[5].st), 32'd1);
      check_val("slow_geom", 32'({hist[6].w[7:0], hist[6].h[7:0], hist[6].t[7:0]}), 32'h06040a);
      check_val("ovf_width", 32'(hist[8].w), 32'd512);
      check_val("ovf_writes", 32'(hist[8].wr), 32'd512);
      check_val("post_rst_geom", 32'({hist[9].w[7:0], hist[9].h[7:0], hist[9].t[7:0]}), 32'h080508);
      check_val("post_rst_stable", 32'(hist[9].st), 32'd0);
      check_val("post_rst_stable2", 32'(hist[10].st), 32'd1);
      if (SIG_EN) begin
        check_val("sig_same", 32'(hist[11].sig == hist[12].sig), 32'd1);
        check_val("sig_diff", 32'(hist[13].sig != hist[12].sig), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
